// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Command encoding, FSM state encoding and requester indices live here
// so the top and the picker agree on them.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MREAD  = 2'b01,
      MWRITE = 2'b10
   } mem_cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RDATA = 2'b10
   } arb_state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DBG = 1'b1;

   // A request only competes when it carries a real read or write;
   // MNONE and the unused 11 encoding are ignored.
   function automatic logic cmd_eligible(input logic req, input logic [1:0] cmd);
      return req && ((cmd == MREAD) || (cmd == MWRITE));
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker for the RAM arbiter.
// Default build: fixed priority to requester 0, except that requester 1
// wins a tie once the starvation count has reached STARVE_MAX.
// With MEM_ARB_RR_EN defined: round-robin, the requester that was not
// granted last wins a tie.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int CNT_W      = 3,
   parameter int STARVE_MAX = 4
) (
   input  logic             elig0,
   input  logic             elig1,
   input  logic [CNT_W-1:0] starve_cnt,
   input  logic             rr_ptr,
   output logic             gnt_valid,
   output logic             gnt_idx
);

`ifdef MEM_ARB_RR_EN
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = starve_cnt;

   // Round-robin: on a tie, hand the grant to whoever did not get the last one.
   always_comb begin
      gnt_valid = elig0 | elig1;
      gnt_idx   = REQ_CPU;
      if (elig0 && elig1) begin
         gnt_idx = ~rr_ptr;
      end else if (elig1) begin
         gnt_idx = REQ_DBG;
      end
   end
`else
   logic unused_rr;
   assign unused_rr = rr_ptr;

   // Fixed priority: the CPU wins ties until the debug port has been passed over too often.
   always_comb begin
      gnt_valid = elig0 | elig1;
      gnt_idx   = REQ_CPU;
      if (elig0 && elig1) begin
         gnt_idx = (starve_cnt >= CNT_W'(STARVE_MAX)) ? REQ_DBG : REQ_CPU;
      end else if (elig1) begin
         gnt_idx = REQ_DBG;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the single-port instruction/data RAM between
// the CPU port (requester 0) and the debug/loader port (requester 1).
// Every access goes IDLE/RDATA -> ISSUE (ack + RAM drive) -> RDATA (reads)
// or back to IDLE (writes). Arbitration only happens leaving IDLE or RDATA.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration instead
// of fixed priority with a starvation limit.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              r0_req,
   input  logic [1:0]        r0_cmd,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic [1:0]        r1_cmd,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              owner
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   arb_state_t        state;
   logic              lat_idx;
   logic              lat_write;
   logic [CNT_W-1:0]  starve_cnt;
   logic              rr_ptr;

   logic              elig0;
   logic              elig1;
   logic              gnt_valid;
   logic              gnt_idx;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_write;

   assign elig0 = cmd_eligible(r0_req, r0_cmd);
   assign elig1 = cmd_eligible(r1_req, r1_cmd);

   mem_arb_pick #(
      .CNT_W      (CNT_W),
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .elig0      (elig0),
      .elig1      (elig1),
      .starve_cnt (starve_cnt),
      .rr_ptr     (rr_ptr),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   // Steer the winning requester's address, data and direction toward the RAM registers.
   always_comb begin
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
      sel_write = (r0_cmd == MWRITE);
      if (gnt_idx == REQ_DBG) begin
         sel_addr  = r1_addr;
         sel_wdata = r1_wdata;
         sel_write = (r1_cmd == MWRITE);
      end
   end

   // Read data is only presented during the rvalid pulse, and comes straight from the RAM.
   assign r0_rdata = r0_rvalid ? mem_dout : '0;
   assign r1_rdata = r1_rvalid ? mem_dout : '0;

   // Access sequencer: latches the winner, drives the RAM for one cycle and pulses ack/rvalid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         lat_idx    <= REQ_CPU;
         lat_write  <= 1'b0;
         starve_cnt <= '0;
         rr_ptr     <= REQ_DBG;
         owner      <= REQ_CPU;
         r0_ack     <= 1'b0;
         r1_ack     <= 1'b0;
         r0_rvalid  <= 1'b0;
         r1_rvalid  <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
      end else begin
         r0_ack    <= 1'b0;
         r1_ack    <= 1'b0;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         mem_write <= 1'b0;
         case (state)
            IDLE, RDATA: begin
               if (gnt_valid) begin
                  state     <= ISSUE;
                  lat_idx   <= gnt_idx;
                  lat_write <= sel_write;
                  owner     <= gnt_idx;
                  rr_ptr    <= gnt_idx;
                  r0_ack    <= (gnt_idx == REQ_CPU);
                  r1_ack    <= (gnt_idx == REQ_DBG);
                  mem_write <= sel_write;
                  mem_addr  <= sel_addr;
                  if (sel_write) begin
                     mem_din <= sel_wdata;
                  end
               end else begin
                  state <= IDLE;
               end
`ifdef MEM_ARB_RR_EN
               starve_cnt <= '0;
`else
               if (gnt_valid && (gnt_idx == REQ_CPU) && elig1) begin
                  starve_cnt <= starve_cnt + 1'b1;
               end else begin
                  starve_cnt <= '0;
               end
`endif
            end
            ISSUE: begin
               if (lat_write) begin
                  state <= IDLE;
               end else begin
                  state     <= RDATA;
                  r0_rvalid <= (lat_idx == REQ_CPU);
                  r1_rvalid <= (lat_idx == REQ_DBG);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM, a transaction
// level reference model (shadow memory plus grant-rule model) and
// directed plus randomized stimulus. Honors MEM_ARB_RR_EN.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 16;
   localparam int STARVE_MAX = 4;

   logic              clk     = 1'b0;
   logic              reset_n = 1'b0;
   logic              r0_req  = 1'b0;
   logic [1:0]        r0_cmd  = 2'b00;
   logic [ADDR_W-1:0] r0_addr = '0;
   logic [DATA_W-1:0] r0_wdata = '0;
   logic              r1_req  = 1'b0;
   logic [1:0]        r1_cmd  = 2'b00;
   logic [ADDR_W-1:0] r1_addr = '0;
   logic [DATA_W-1:0] r1_wdata = '0;
   logic              r0_ack, r1_ack, r0_rvalid, r1_rvalid;
   logic [DATA_W-1:0] r0_rdata, r1_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic              owner;

   logic [DATA_W-1:0] ram       [0:255];
   logic [DATA_W-1:0] model_mem [0:255];

   bit                act    [2];
   logic [1:0]        cmd_a  [2];
   logic [ADDR_W-1:0] addr_a [2];
   logic [DATA_W-1:0] data_a [2];
   bit                exp_rv [2];
   logic [DATA_W-1:0] exp_rd [2];
   int                wait_cnt [2];
   int                model_cnt;
   int                model_last;
   int                grant_log [$];
   int                checks = 0;
   int                errors = 0;

   mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .r0_req    (r0_req),
      .r0_cmd    (r0_cmd),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_ack    (r0_ack),
      .r0_rvalid (r0_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_req    (r1_req),
      .r1_cmd    (r1_cmd),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_ack    (r1_ack),
      .r1_rvalid (r1_rvalid),
      .r1_rdata  (r1_rdata),
      .mem_addr  (mem_addr),
      .mem_write (mem_write),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .owner     (owner)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Single-port RAM: synchronous write, registered read (read-before-write).
   always @(posedge clk) begin
      mem_dout <= ram[mem_addr];
      if (mem_write) ram[mem_addr] = mem_din;
   end

   // Hard stop in case something wedges the main sequence.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus();
      r0_req = act[0]; r0_cmd = cmd_a[0]; r0_addr = addr_a[0]; r0_wdata = data_a[0];
      r1_req = act[1]; r1_cmd = cmd_a[1]; r1_addr = addr_a[1]; r1_wdata = data_a[1];
   endtask

   task automatic resetModel();
      model_cnt  = 0;
      model_last = 1;
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; exp_rv[i] = 1'b0; wait_cnt[i] = 0;
      end
      applyStimulus();
   endtask

   // One isolated access from an idle arbiter: ack one cycle after the request, rvalid one later.
   task automatic singleTxn(input int idx, input logic [1:0] cmd, input logic [7:0] a, input logic [15:0] d);
      logic [15:0] exp_data;
      act[idx] = 1'b1; cmd_a[idx] = cmd; addr_a[idx] = a; data_a[idx] = d;
      applyStimulus();
      @(negedge clk);
      checkOutput("txn_ack",       32'(idx == 0 ? r0_ack : r1_ack), 32'd1);
      checkOutput("txn_other_ack", 32'(idx == 0 ? r1_ack : r0_ack), 32'd0);
      checkOutput("txn_owner",     32'(owner), 32'(idx));
      checkOutput("txn_mem_write", 32'(mem_write), 32'(cmd == MWRITE));
      checkOutput("txn_mem_addr",  32'(mem_addr), 32'(a));
      if (cmd == MWRITE) checkOutput("txn_mem_din", 32'(mem_din), 32'(d));
      act[idx] = 1'b0;
      applyStimulus();
      if (cmd == MWRITE) begin
         model_mem[a] = d;
         @(negedge clk);
         checkOutput("txn_ram_word", 32'(ram[a]), 32'(d));
         checkOutput("txn_no_rvalid", 32'(r0_rvalid | r1_rvalid), 32'd0);
         checkOutput("txn_rdata_zero", 32'(r0_rdata | r1_rdata), 32'd0);
         checkOutput("txn_write_low", 32'(mem_write), 32'd0);
      end else begin
         exp_data = model_mem[a];
         @(negedge clk);
         checkOutput("txn_rvalid",       32'(idx == 0 ? r0_rvalid : r1_rvalid), 32'd1);
         checkOutput("txn_rdata",        32'(idx == 0 ? r0_rdata : r1_rdata), 32'(exp_data));
         checkOutput("txn_other_rvalid", 32'(idx == 0 ? r1_rvalid : r0_rvalid), 32'd0);
         @(negedge clk);
         checkOutput("txn_rvalid_drop", 32'(r0_rvalid | r1_rvalid), 32'd0);
         checkOutput("txn_rdata_drop",  32'(r0_rdata | r1_rdata), 32'd0);
      end
   endtask

   // One clock of the free-running engine. mode 0: no new requests,
   // 1: both ports re-issue reads at once, 2: random traffic.
   task automatic cycleStep(input int mode);
      bit e0, e1;
      bit ack_v [2];
      bit rv_v [2];
      logic [15:0] rd_v [2];
      int exp_w;
      @(negedge clk);
      ack_v[0] = r0_ack;    ack_v[1] = r1_ack;
      rv_v[0]  = r0_rvalid; rv_v[1]  = r1_rvalid;
      rd_v[0]  = r0_rdata;  rd_v[1]  = r1_rdata;
      checkOutput("single_ack", 32'(r0_ack & r1_ack), 32'd0);
      checkOutput("single_rvalid", 32'(r0_rvalid & r1_rvalid), 32'd0);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("r%0d_rvalid", i), 32'(rv_v[i]), 32'(exp_rv[i]));
         checkOutput($sformatf("r%0d_rdata", i), 32'(rd_v[i]), exp_rv[i] ? 32'(exp_rd[i]) : 32'd0);
         exp_rv[i] = 1'b0;
      end
      if (!ack_v[0] && !ack_v[1]) checkOutput("mem_write_no_ack", 32'(mem_write), 32'd0);
      e0 = act[0];
      e1 = act[1];
      for (int i = 0; i < 2; i++) begin
         if (ack_v[i]) begin
            checkOutput($sformatf("r%0d_ack_has_req", i), 32'(act[i]), 32'd1);
            if (act[i]) begin
               if (e0 && e1) begin
`ifdef MEM_ARB_RR_EN
                  exp_w = 1 - model_last;
`else
                  exp_w = (model_cnt >= STARVE_MAX) ? 1 : 0;
`endif
               end else begin
                  exp_w = e1 ? 1 : 0;
               end
               checkOutput("grant_winner", 32'(i), 32'(exp_w));
`ifdef MEM_ARB_RR_EN
               model_last = i;
`else
               model_cnt = (i == 0 && e1) ? model_cnt + 1 : 0;
`endif
               checkOutput("owner", 32'(owner), 32'(i));
               checkOutput("mem_addr", 32'(mem_addr), 32'(addr_a[i]));
               checkOutput("mem_write", 32'(mem_write), 32'(cmd_a[i] == MWRITE));
               if (cmd_a[i] == MWRITE) begin
                  checkOutput("mem_din", 32'(mem_din), 32'(data_a[i]));
                  model_mem[addr_a[i]] = data_a[i];
               end else begin
                  exp_rv[i] = 1'b1;
                  exp_rd[i] = model_mem[addr_a[i]];
               end
               grant_log.push_back(i);
               act[i] = 1'b0;
               wait_cnt[i] = 0;
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (act[i]) begin
            wait_cnt[i]++;
            if (wait_cnt[i] > 40) begin
               checkOutput($sformatf("r%0d_ack_timeout", i), 32'(wait_cnt[i]), 32'd40);
               act[i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (!act[i]) begin
            if (mode == 1) begin
               act[i] = 1'b1; cmd_a[i] = MREAD;
               addr_a[i] = 8'($urandom_range(0, 15)); data_a[i] = 16'($urandom);
            end else if (mode == 2 && $urandom_range(0, 2) == 0) begin
               act[i] = 1'b1;
               cmd_a[i] = ($urandom_range(0, 1) == 1) ? MWRITE : MREAD;
               addr_a[i] = 8'($urandom_range(0, 15)); data_a[i] = 16'($urandom);
            end
         end
      end
      applyStimulus();
   endtask

   task automatic drain();
      for (int c = 0; c < 60 && (act[0] || act[1]); c++) cycleStep(0);
      checkOutput("drain_done", 32'(act[0] | act[1]), 32'd0);
      repeat (3) cycleStep(0);
   endtask

   initial begin
      int exp_order [10];
      int n;
`ifdef MEM_ARB_RR_EN
      exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
      exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
      for (int i = 0; i < 256; i++) begin
         ram[i]       = 16'(i * 16'h0101) ^ 16'h5A00;
         model_mem[i] = ram[i];
      end
      ram[5] = 16'hABCD; model_mem[5] = 16'hABCD;
      for (int i = 0; i < 2; i++) begin
         cmd_a[i] = MNONE; addr_a[i] = '0; data_a[i] = '0;
      end
      resetModel();

      // Reset held for three cycles: every output at zero.
      repeat (3) @(negedge clk);
      checkOutput("rst_acks",    32'({r0_ack, r1_ack}), 32'd0);
      checkOutput("rst_rvalids", 32'({r0_rvalid, r1_rvalid}), 32'd0);
      checkOutput("rst_rdatas",  32'(r0_rdata | r1_rdata), 32'd0);
      checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
      checkOutput("rst_mem_addr",  32'(mem_addr), 32'd0);
      checkOutput("rst_mem_din",   32'(mem_din), 32'd0);
      checkOutput("rst_owner",     32'(owner), 32'd0);
      reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("idle_mem_write", 32'(mem_write), 32'd0);
      end

      // Directed write from the debug port, then a CPU read.
      singleTxn(1, MWRITE, 8'h06, 16'hABCD);
      @(negedge clk);
      singleTxn(0, MREAD, 8'h05, 16'h0000);

      // MNONE and 11 are never accepted.
      act[0] = 1'b1; cmd_a[0] = 2'b00; applyStimulus();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checkOutput("mnone_ack", 32'(r0_ack), 32'd0);
         checkOutput("mnone_write", 32'(mem_write), 32'd0);
      end
      cmd_a[0] = 2'b11; applyStimulus();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checkOutput("cmd11_ack", 32'(r0_ack), 32'd0);
         checkOutput("cmd11_write", 32'(mem_write), 32'd0);
      end
      checkOutput("cmd_ignored_starve", 32'(dut.starve_cnt), 32'd0);
      act[0] = 1'b0; cmd_a[0] = MNONE; applyStimulus();
      @(negedge clk);

      // Reset during the ISSUE cycle of a CPU write.
      act[0] = 1'b1; cmd_a[0] = MWRITE; addr_a[0] = 8'h10; data_a[0] = 16'h5A5A;
      applyStimulus();
      @(posedge clk);
      #2;
      checkOutput("midrst_write_before", 32'(mem_write), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_write_drop", 32'(mem_write), 32'd0);
      checkOutput("midrst_no_ack", 32'(r0_ack), 32'd0);
      resetModel();
      repeat (2) begin
         @(negedge clk);
         checkOutput("midrst_ack_low", 32'(r0_ack | r1_ack), 32'd0);
         checkOutput("midrst_rvalid_low", 32'(r0_rvalid | r1_rvalid), 32'd0);
      end
      checkOutput("midrst_ram_kept", 32'(ram[8'h10]), 32'(model_mem[8'h10]));
      reset_n = 1'b1;
      singleTxn(0, MREAD, 8'h10, 16'h0000);

      // Fresh reset, then both ports reading back-to-back.
      @(negedge clk);
      reset_n = 1'b0;
      resetModel();
      @(negedge clk);
      reset_n = 1'b1;
      grant_log.delete();
      repeat (40) cycleStep(1);
      drain();
      n = grant_log.size();
      checkOutput("contend_grants", 32'(n >= 10), 32'd1);
      for (int k = 0; k < 10 && k < n; k++) begin
         checkOutput($sformatf("contend_order_%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));
      end

      // Randomized mixed traffic against the model.
      repeat (400) cycleStep(2);
      drain();
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("ram_final_%0d", i), 32'(ram[i]), 32'(model_mem[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
